// File: rtl/eh2_exu_mul_wb_q.sv
// eh2_exu_mul_wb_q: tracks multiplier destination tags through E1-E3, applies thread flushes, and queues results for writeback with upstream credits
module eh2_exu_mul_wb_q #(
  parameter int QDEPTH = 4,
  parameter int RDW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           issue_valid,
  input  logic           issue_tid,
  input  logic [RDW-1:0] issue_rd,
  output logic           issue_ready,
  input  logic           flush_valid,
  input  logic           flush_tid,
  input  logic [31:0]    mul_out,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic           wb_tid,
  output logic [RDW-1:0] wb_rd,
  output logic [31:0]    wb_data,
  output logic [3:0]     occupancy,
  output logic           proto_err
);
  localparam int PW = $clog2(QDEPTH);
  logic [2:0] r_v, r_tid;
  logic [RDW-1:0] r_rd [3];
  logic [QDEPTH-1:0] r_qtid;
  logic [RDW-1:0] r_qrd [QDEPTH];
  logic [31:0] r_qdata [QDEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [3:0] r_cnt;
  logic r_perr;
  logic [2:0] w_kill;
  logic [3:0] w_pipe_cnt;
  logic w_acc, w_push, w_pop;
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    w_kill = {3{flush_valid}} & r_v & ~(r_tid ^ {3{flush_tid}});
    w_pipe_cnt = 4'(r_v[0]) + 4'(r_v[1]) + 4'(r_v[2]);
    occupancy = w_pipe_cnt + r_cnt;
    issue_ready = occupancy < 4'(QDEPTH);
    w_acc = issue_valid & issue_ready & ~(flush_valid & (flush_tid == issue_tid));
    w_push = r_v[2] & ~w_kill[2];
    wb_valid = r_cnt != 4'd0;
    w_pop = wb_valid & wb_ready;
    wb_tid = wb_valid & r_qtid[r_head];
    wb_rd = wb_valid ? r_qrd[r_head] : '0;
    wb_data = wb_valid ? r_qdata[r_head] : '0;
    proto_err = r_perr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt <= '0;
      r_perr <= 1'b0;
    end else begin
      r_v <= {r_v[1] & ~w_kill[1], r_v[0] & ~w_kill[0], w_acc};
      r_head <= w_pop ? f_inc(r_head) : r_head;
      r_tail <= w_push ? f_inc(r_tail) : r_tail;
      r_cnt <= r_cnt + 4'(w_push) - 4'(w_pop);
      r_perr <= r_perr | (issue_valid & ~issue_ready);
    end
  end
  always_ff @(posedge clk) begin
    r_tid <= {r_tid[1:0], issue_tid};
    r_rd[0] <= issue_rd;
    r_rd[1] <= r_rd[0];
    r_rd[2] <= r_rd[1];
    if (w_push) begin
      r_qtid[r_tail] <= r_tid[2];
      r_qrd[r_tail] <= r_rd[2];
      r_qdata[r_tail] <= mul_out;
    end
  end
endmodule

// File: tb/tb_eh2_exu_mul_wb_q.sv
// tb_eh2_exu_mul_wb_q: directed stimulus with a queue-based reference model compared every cycle
module tb_eh2_exu_mul_wb_q;
  localparam int QD = 4;
  logic clk = 1'b0;
  logic rst, issue_valid, issue_tid, issue_ready, flush_valid, flush_tid;
  logic [4:0] issue_rd, wb_rd;
  logic [31:0] mul_out, wb_data, issue_val, last_wb;
  logic wb_valid, wb_ready, wb_tid, proto_err;
  logic [3:0] occupancy;
  logic [31:0] m1, m2, m3;
  int checks = 0, errors = 0, n_wb = 0;
  typedef struct {bit tid; bit [4:0] rd; int age;} pe_t;
  typedef struct {bit tid; bit [4:0] rd; bit [31:0] data;} fe_t;
  pe_t infl[$];
  fe_t fq[$];
  bit m_perr;
  always #5 clk = ~clk;
  eh2_exu_mul_wb_q #(.QDEPTH(QD), .RDW(5)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tid(issue_tid),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .flush_valid(flush_valid),
    .flush_tid(flush_tid), .mul_out(mul_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_tid(wb_tid), .wb_rd(wb_rd), .wb_data(wb_data), .occupancy(occupancy),
    .proto_err(proto_err)
  );
  always @(posedge clk) begin
    m1 <= issue_valid ? issue_val : 32'hdead_beef;
    m2 <= m1;
    m3 <= m2;
  end
  assign mul_out = m3;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    pe_t nq[$];
    pe_t e;
    bit rdy;
    if (rst) begin
      infl.delete();
      fq.delete();
      m_perr = 0;
      return;
    end
    rdy = (infl.size() + fq.size()) < QD;
    if (issue_valid && !rdy) m_perr = 1;
    if (fq.size() > 0 && wb_ready) void'(fq.pop_front());
    foreach (infl[i]) begin
      if (flush_valid && infl[i].tid == flush_tid) continue;
      if (infl[i].age == 3) begin
        if (fq.size() >= QD) begin
          errors++;
          $display("FAIL model_overflow: fifo size %0d limit %0d", fq.size(), QD);
        end
        fq.push_back('{infl[i].tid, infl[i].rd, mul_out});
      end else begin
        e = infl[i];
        e.age++;
        nq.push_back(e);
      end
    end
    if (issue_valid && rdy && !(flush_valid && flush_tid == issue_tid))
      nq.push_back('{issue_tid, issue_rd, 1});
    infl = nq;
  endtask
  initial forever begin
    @(posedge clk);
    if (!rst && wb_valid && wb_ready) begin
      n_wb++;
      last_wb = wb_data;
    end
    model_step();
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("wb_valid", 32'(wb_valid), 32'(fq.size() > 0));
      if (fq.size() > 0) begin
        chk("wb_tid", 32'(wb_tid), 32'(fq[0].tid));
        chk("wb_rd", 32'(wb_rd), 32'(fq[0].rd));
        chk("wb_data", wb_data, fq[0].data);
      end
      chk("occupancy", 32'(occupancy), 32'(infl.size() + fq.size()));
      chk("issue_ready", 32'(issue_ready), 32'((infl.size() + fq.size()) < QD));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue(input bit t, input bit [4:0] rd, input bit [31:0] v);
    issue_valid = 1;
    issue_tid = t;
    issue_rd = rd;
    issue_val = v;
  endtask
  initial begin
    int k, n0;
    rst = 1;
    issue_valid = 0; issue_tid = 0; issue_rd = 0; issue_val = 0;
    flush_valid = 0; flush_tid = 0; wb_ready = 0;
    tick();
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_wbv", 32'(wb_valid), 0);
    chk("rst_perr", 32'(proto_err), 0);
    rst = 0;
    wb_ready = 1;
    issue(0, 7, 32'h15);
    tick();
    issue_valid = 0;
    chk("single_occ_s1", 32'(occupancy), 1);
    tick(3);
    chk("single_wbv", 32'(wb_valid), 1);
    chk("single_rd", 32'(wb_rd), 7);
    chk("single_tid", 32'(wb_tid), 0);
    chk("single_data", wb_data, 32'h15);
    tick();
    chk("single_occ_end", 32'(occupancy), 0);
    wb_ready = 0;
    for (int i = 0; i < 4; i++) begin
      issue(i[0], 5'(8 + i), 32'(11 + i));
      tick();
    end
    issue_valid = 0;
    chk("stall_occ", 32'(occupancy), 4);
    chk("stall_ready", 32'(issue_ready), 0);
    issue(0, 20, 32'h77);
    tick();
    issue_valid = 0;
    chk("proto_set", 32'(proto_err), 1);
    tick(3);
    chk("stall_occ2", 32'(occupancy), 4);
    chk("stall_head", wb_data, 32'd11);
    wb_ready = 1;
    tick();
    chk("drain_credit", 32'(occupancy), 3);
    tick(3);
    chk("drain_last", last_wb, 32'd14);
    chk("drain_occ", 32'(occupancy), 0);
    chk("proto_sticky", 32'(proto_err), 1);
    n0 = n_wb;
    issue(0, 1, 32'hA); tick();
    issue(1, 2, 32'hB); tick();
    issue(0, 3, 32'hC); tick();
    issue_valid = 0;
    flush_valid = 1;
    flush_tid = 0;
    chk("flush_pre", 32'(occupancy), 3);
    tick();
    flush_valid = 0;
    chk("flush_post", 32'(occupancy), 1);
    tick();
    chk("flush_wbv", 32'(wb_valid), 1);
    chk("flush_tid1", 32'(wb_tid), 1);
    chk("flush_rd", 32'(wb_rd), 2);
    chk("flush_data", wb_data, 32'hB);
    tick(4);
    chk("flush_count", 32'(n_wb - n0), 1);
    n0 = n_wb;
    issue(1, 9, 32'h99);
    flush_valid = 1;
    flush_tid = 1;
    tick();
    issue_valid = 0;
    flush_valid = 0;
    chk("fsame_occ", 32'(occupancy), 0);
    tick(5);
    chk("fsame_nowb", 32'(n_wb - n0), 0);
    n0 = n_wb;
    k = 1;
    for (int c = 0; c < 200 && (k <= 10 || occupancy != 0); c++) begin
      wb_ready = c >= 6;
      if (k <= 10 && issue_ready) begin
        issue(k[0], 5'(k), 32'(k));
        k++;
      end else issue_valid = 0;
      tick();
    end
    issue_valid = 0;
    wb_ready = 1;
    chk("wrap_issued", 32'(k), 11);
    chk("wrap_count", 32'(n_wb - n0), 10);
    chk("wrap_last", last_wb, 32'd10);
    n0 = n_wb;
    wb_ready = 0;
    issue(0, 4, 32'h44); tick();
    issue(1, 5, 32'h55); tick();
    issue(0, 6, 32'h66); tick();
    issue(1, 7, 32'h67); tick();
    issue_valid = 0;
    tick(2);
    wb_ready = 1;
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_wbv", 32'(wb_valid), 0);
    chk("mrst_occ", 32'(occupancy), 0);
    chk("mrst_ready", 32'(issue_ready), 1);
    chk("mrst_perr", 32'(proto_err), 0);
    chk("mrst_data", wb_data, 0);
    tick(6);
    chk("mrst_nowb", 32'(n_wb - n0), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
